// File: rtl/sprite_draw_engine.sv
// Sprite draw engine: executes Dxyn draws and 00E0 clears on a 64x32 monochrome framebuffer.
// Define SPRITE_WRAP_EN to wrap off-screen sprite pixels around the edges instead of clipping them.
module sprite_draw_engine #(
  parameter int FB_W   = 64,
  parameter int FB_H   = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              draw_start,
  input  logic [7:0]        draw_x,
  input  logic [7:0]        draw_y,
  input  logic [3:0]        draw_rows,
  input  logic [ADDR_W-1:0] draw_base,
  input  logic              clear_display,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic              draw_collision,
  input  logic [4:0]        disp_row_sel,
  output logic [FB_W-1:0]   disp_row_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_XOR,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [5:0]        x0_q, x0_d;
  logic [4:0]        y0_q, y0_d;
  logic [3:0]        n_q, n_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0]        row_q, row_d;
  logic [4:0]        clr_row_q, clr_row_d;
  logic [FB_W-1:0]   fb_q [FB_H];
  logic [FB_W-1:0]   fb_d [FB_H];
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              coll_q, coll_d;
  logic [FB_W-1:0]   disp_q, disp_d;

  logic [7:0]        sprite_rev;
  logic [FB_W-1:0]   sprite_wide;
  logic [FB_W-1:0]   mask;
  logic [5:0]        tgt_row_full;
  logic [4:0]        tgt_row;
  logic              row_in_range;
  logic              unused_bits;

  assign unused_bits = ^{draw_x[7:6], draw_y[7:5], tgt_row_full[5]};

  // Sprite bit 7-k lands on column x0+k, so the byte is bit-reversed before shifting.
  always_comb begin
    for (int k = 0; k < 8; k++) sprite_rev[k] = mem_data[7-k];
    sprite_wide  = {{(FB_W-8){1'b0}}, sprite_rev};
    tgt_row_full = {1'b0, y0_q} + {2'b00, row_q};
    tgt_row      = tgt_row_full[4:0];
`ifdef SPRITE_WRAP_EN
    mask         = (sprite_wide << x0_q) | (sprite_wide >> (7'(FB_W) - {1'b0, x0_q}));
    row_in_range = 1'b1;
`else
    mask         = sprite_wide << x0_q;
    row_in_range = ~tgt_row_full[5];
`endif
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    n_d         = n_q;
    base_d      = base_q;
    row_d       = row_q;
    clr_row_d   = clr_row_q;
    fb_d        = fb_q;
    mem_addr_d  = mem_addr_q;
    coll_d      = coll_q;
    disp_d      = fb_q[disp_row_sel];

    unique case (state_q)
      S_IDLE: begin
        if (clear_display) begin
          state_d   = S_CLEAR;
          clr_row_d = '0;
        end else if (draw_start) begin
          x0_d   = draw_x[5:0];
          y0_d   = draw_y[4:0];
          n_d    = draw_rows;
          base_d = draw_base;
          row_d  = '0;
          coll_d = 1'b0;
          if (draw_rows == 4'd0) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_FETCH;
            mem_addr_d = draw_base;
          end
        end
      end
      S_CLEAR: begin
        fb_d[clr_row_q] = '0;
        clr_row_d       = clr_row_q + 5'd1;
        if (clr_row_q == 5'(FB_H - 1)) state_d = S_DONE;
      end
      S_FETCH: state_d = S_XOR;
      S_XOR: begin
        if (row_in_range) begin
          fb_d[tgt_row] = fb_q[tgt_row] ^ mask;
          if (|(fb_q[tgt_row] & mask)) coll_d = 1'b1;
        end
        row_d = row_q + 4'd1;
        if (row_d == n_q) begin
          state_d = S_DONE;
        end else begin
          state_d    = S_FETCH;
          mem_addr_d = base_q + {{(ADDR_W-4){1'b0}}, row_d};
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d == S_CLEAR) || (state_d == S_FETCH) || (state_d == S_XOR);
    done_d      = (state_d == S_DONE);
    mem_rd_en_d = (state_d == S_FETCH);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      n_q         <= '0;
      base_q      <= '0;
      row_q       <= '0;
      clr_row_q   <= '0;
      // NOTE: the framebuffer is built from flops, not a RAM macro, so it can clear in one reset cycle.
      fb_q        <= '{default: '0};
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      coll_q      <= 1'b0;
      disp_q      <= '0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      n_q         <= n_d;
      base_q      <= base_d;
      row_q       <= row_d;
      clr_row_q   <= clr_row_d;
      fb_q        <= fb_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_en_q <= mem_rd_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      coll_q      <= coll_d;
      disp_q      <= disp_d;
    end
  end

  assign mem_addr       = mem_addr_q;
  assign mem_rd_en      = mem_rd_en_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign draw_collision = coll_q;
  assign disp_row_data  = disp_q;

endmodule
